// File: rtl/s_seq_loader.sv
// Query-sequence loader: buffers packed host words, then streams one 2-bit base per cycle into the S ring.
// Optional macro S_LOADER_PAD_EN: pad every stream to REG_NUM bases with 2'b00.
module s_seq_loader #(
  parameter int REG_NUM = 128,
  parameter int WORD_W  = 32,
  parameter int LEN_W   = $clog2(REG_NUM) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  seq_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              valid,
  output logic [1:0]        s_out,
  output logic              busy,
  output logic              done
);

  localparam int BPW    = WORD_W / 2;
  localparam int NWORDS = (REG_NUM + BPW - 1) / BPW;
  localparam int WI_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int NSLOT  = 1 << WI_W;
  localparam int WC_W   = $clog2(NWORDS + 1);
  localparam int BPOS_W = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [LEN_W-1:0]  REG_NUM_L = LEN_W'(REG_NUM);
  localparam logic [WC_W-1:0]   WC_ONE    = WC_W'(1);
  localparam logic [BPOS_W-1:0] BPOS_LAST = BPOS_W'(BPW - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM, S_DONE} state_t;

  state_t              r_state;
  logic [WORD_W-1:0]   r_buf [NSLOT];
  logic [LEN_W-1:0]    r_len;
  logic [WC_W-1:0]     r_nw;
  logic [WC_W-1:0]     r_wcnt;
  logic [LEN_W-1:0]    r_bcnt;
  logic [BPOS_W-1:0]   r_bpos;
  logic [WI_W-1:0]     r_rw;
  logic                r_in_ready;
  logic                r_valid;
  logic [1:0]          r_s_out;
  logic                r_busy;
  logic                r_done;

  logic [LEN_W-1:0]         w_len_eff;
  logic [WC_W-1:0]          w_nw;
  logic                     w_accept;
  logic                     w_last_word;
  logic [WORD_W-1:0]        w_rd_word;
  logic [BPW-1:0][1:0]      w_rd_bases;
  logic [1:0]               w_base;
  logic [LEN_W-1:0]         w_stop;
  logic [BPOS_W-1:0]        w_bpos_nx;
  logic [WI_W-1:0]          w_rw_nx;

  assign w_len_eff   = (seq_len > REG_NUM_L) ? REG_NUM_L : seq_len;
  assign w_nw        = WC_W'((32'(w_len_eff) + 32'(BPW - 1)) / 32'(BPW));
  assign w_accept    = r_in_ready & in_valid;
  assign w_last_word = w_accept && (r_wcnt == (r_nw - WC_ONE));

  // Base 0 may live in the word being accepted this very cycle, so bypass the buffer.
  assign w_rd_word   = ((r_state == S_FILL) && (r_wcnt == '0)) ? in_data : r_buf[r_rw];
  assign w_rd_bases  = w_rd_word;

`ifdef S_LOADER_PAD_EN
  assign w_stop = REG_NUM_L;
  assign w_base = (r_bcnt < r_len) ? w_rd_bases[r_bpos] : 2'b00;
`else
  assign w_stop = r_len;
  assign w_base = w_rd_bases[r_bpos];
`endif

  assign w_bpos_nx = (r_bpos == BPOS_LAST) ? '0 : r_bpos + BPOS_W'(1);
  assign w_rw_nx   = (r_bpos == BPOS_LAST) ? r_rw + WI_W'(1) : r_rw;

  always_ff @(posedge clk) begin
    if (w_accept) r_buf[r_wcnt[WI_W-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_nw       <= '0;
      r_wcnt     <= '0;
      r_bcnt     <= '0;
      r_bpos     <= '0;
      r_rw       <= '0;
      r_in_ready <= 1'b0;
      r_valid    <= 1'b0;
      r_s_out    <= 2'b00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len  <= w_len_eff;
            r_nw   <= w_nw;
            r_wcnt <= '0;
            r_busy <= 1'b1;
            if (w_nw != '0) begin
              r_state    <= S_FILL;
              r_in_ready <= 1'b1;
              r_bcnt     <= '0;
              r_bpos     <= '0;
              r_rw       <= '0;
            end else begin
`ifdef S_LOADER_PAD_EN
              // Counters are zero in IDLE, so this emits pad index 0 and advances to 1.
              r_state <= S_STREAM;
              r_valid <= 1'b1;
              r_s_out <= 2'b00;
              r_bcnt  <= LEN_W'(1);
              r_bpos  <= w_bpos_nx;
              r_rw    <= w_rw_nx;
`else
              r_state <= S_DONE;
              r_done  <= 1'b1;
`endif
            end
          end
        end

        S_FILL: begin
          if (w_accept) begin
            r_wcnt <= r_wcnt + WC_ONE;
            if (w_last_word) begin
              r_state    <= S_STREAM;
              r_in_ready <= 1'b0;
              r_valid    <= 1'b1;
              r_s_out    <= w_base;
              r_bcnt     <= r_bcnt + LEN_W'(1);
              r_bpos     <= w_bpos_nx;
              r_rw       <= w_rw_nx;
            end
          end
        end

        S_STREAM: begin
          if (r_bcnt == w_stop) begin
            r_state <= S_DONE;
            r_valid <= 1'b0;
            r_s_out <= 2'b00;
            r_done  <= 1'b1;
          end else begin
            r_s_out <= w_base;
            r_bcnt  <= r_bcnt + LEN_W'(1);
            r_bpos  <= w_bpos_nx;
            r_rw    <= w_rw_nx;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_wcnt  <= '0;
          r_bcnt  <= '0;
          r_bpos  <= '0;
          r_rw    <= '0;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign valid    = r_valid;
  assign s_out    = r_s_out;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: doc/s_seq_loader.md
# s_seq_loader

Buffers a packed query sequence from the host-side word interface and streams it, one 2-bit base per cycle, into the S register ring of the Smith-Waterman systolic array. It drives that ring's `valid`/`s_in` pair. It holds `valid` high for one contiguous burst, because any gap would make the ring recirculate mid-load and corrupt the sequence. It sits between the host/DMA word port and the S register ring.

## Interface
- `REG_NUM`, 128, number of S ring positions; also the maximum sequence length.
- `WORD_W`, 32, input word width; must be an even multiple of 2. `BPW = WORD_W/2` bases per word.
- `LEN_W`, `$clog2(REG_NUM)+1`, width of `seq_len`.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to load a new sequence; honoured only in IDLE.
- `seq_len`  in  LEN_W  number of bases; sampled with `start`.
- `in_valid`  in  1  host word valid.
- `in_ready`  out  1  loader accepts a word this cycle.
- `in_data`  in  WORD_W  packed bases; base k of the word is at bits [2k+1:2k], base 0 is sent first.
- `valid`  out  1  to the S ring: load `s_out` this cycle.
- `s_out`  out  2  base to the S ring.
- `busy`  out  1  high in FILL, STREAM and DONE.
- `done`  out  1  one-cycle pulse when the stream is complete.

## Operation
- Effective length: `len_eff = min(seq_len, REG_NUM)`. Latched at `start`.
- Words required: `nw = ceil(len_eff / BPW)`. This is 0 when `len_eff = 0`.
- Internal buffer: `REG_NUM/BPW` words (`REG_NUM*2` bits). Word j is written to slot j. A word counter and a base counter are sized to their maxima.
- FSM states:
  - IDLE: `start=1` latches `len_eff` and clears the counters. Next state is FILL if `nw>0`. Otherwise it is STREAM with the pad feature, or DONE without it. `start` outside IDLE is ignored.
  - FILL: `in_ready=1`. Each cycle with `in_valid & in_ready` stores one word. Accepting word `nw-1` moves to STREAM. Gaps in `in_valid` simply wait; there is no timeout.
  - STREAM: `valid=1` every cycle. `s_out` = buffer base `i`, with i running 0,1,2,…. Bases at index ≥ `len_eff` output the pad code 2'b00. The state lasts `N` cycles, then moves to DONE.
  - DONE: `done=1` for one cycle, then IDLE.
- Base bits of a partially used final word beyond `len_eff` are never emitted as sequence data; the pad code is substituted.
- `valid` and `s_out` are registered outputs. `s_out` is 2'b00 whenever `valid=0`.

## Timing
- Reset values: state IDLE, `in_ready=0`, `valid=0`, `s_out=2'b00`, `busy=0`, `done=0`. Counters are 0. Buffer contents are don't-care.
- `start` sampled at cycle t: `busy` and `in_ready` are high from t+1.
- Last word accepted at cycle f: `valid` is high on cycles f+1 … f+N. `done` is high at f+N+1. IDLE and `busy=0` from f+N+2.
- When `nw=0` with pad enabled: `valid` on t+1 … t+N, `done` at t+N+1.
- `in_ready` is low in every state except FILL. No word is accepted outside FILL.
- `valid` is never deasserted inside STREAM (contiguity is mandatory).
- Reset asserted mid-FILL or mid-STREAM: outputs are forced to reset values immediately. Any partial load already shifted into the ring is the consumer's problem; the loader does not resume.
- `start` coinciding with `done`: ignored, because the state is not IDLE.

## Configuration
- `S_LOADER_PAD_EN` defined: `N = REG_NUM`. Every stream fills the whole ring, with positions ≥ `len_eff` set to 2'b00.
- Not defined: `N = len_eff`. Only real bases are streamed. `len_eff=0` goes IDLE→DONE, gives `done` at t+1, and never asserts `valid`. Pad logic is removed.

## Test plan
- Full sequence: `seq_len=128`, 8 words with no gaps, base i = i mod 4 → 128 contiguous `valid` cycles, `s_out` = i mod 4, `done` one cycle after the last base.
- Short sequence with pad enabled: `seq_len=5`, one word 0xFFFF_FFE4 → `s_out` = 0,1,2,3,3, then 123 × 2'b00, for 128 `valid` cycles. Without the macro, only 5 `valid` cycles.
- Zero length: `seq_len=0` → no `in_ready` cycle; `valid` for 128 cycles with the macro, or `done` at t+1 without it.
- Clamp and backpressure: `seq_len=200`, `in_valid` toggled every other cycle → exactly 8 words accepted, `valid` starts the cycle after the 8th word, and there are no gaps in `valid`.
- Reset mid-STREAM: `reset` low at stream cycle 40 → `valid`, `busy` and `done` go 0 immediately. After release, a new `start` runs a full load correctly.
- `start` pulsed during FILL and during DONE → ignored; `len_eff` is unchanged and exactly one `done` pulse occurs.
